// File: rtl/hnf_mshr_excl_status.sv
// hnf_mshr_excl_status: per-MSHR-entry exclusive-access status tracker.
// An entry goes to PEND when an exclusive request is allocated in s0. The
// global monitor verdict one cycle later (s1) turns it into PASS or FAIL.
// Response generation looks the entry up and gets RespErr plus a write-drop
// flag one cycle later.
// Optional feature macro: HNF_MSHR_EXCL_STAT_EN adds saturating pass/fail
// event counters and their two output ports.
module hnf_mshr_excl_status #(
  parameter int HNF_MSHR_ENTRIES_NUM_PARAM   = 32,
  parameter int HNF_MSHR_ENTRIES_WIDTH_PARAM = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    mshr_alloc_en_s0,
  input  logic [HNF_MSHR_ENTRIES_WIDTH_PARAM-1:0] mshr_alloc_entry_s0,
  input  logic                                    li_mshr_rxreq_valid_s0,
  input  logic                                    li_mshr_rxreq_excl_s0,
  input  logic                                    excl_pass_s1,
  input  logic                                    excl_fail_s1,
  input  logic                                    rsp_query_valid,
  input  logic [HNF_MSHR_ENTRIES_WIDTH_PARAM-1:0] rsp_query_entry,
  output logic [1:0]                              rsp_resperr_q,
  output logic                                    rsp_wrdata_drop_q,
  input  logic                                    mshr_dealloc_en,
  input  logic [HNF_MSHR_ENTRIES_WIDTH_PARAM-1:0] mshr_dealloc_entry
`ifdef HNF_MSHR_EXCL_STAT_EN
  ,output logic [15:0]                            excl_pass_cnt_q
  ,output logic [15:0]                            excl_fail_cnt_q
`endif
);

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [1:0] RESP_OK   = 2'b00;
  localparam logic [1:0] RESP_EXOK = 2'b01;

  logic [1:0]                              state_r     [HNF_MSHR_ENTRIES_NUM_PARAM];
  logic [1:0]                              state_nxt_s [HNF_MSHR_ENTRIES_NUM_PARAM];
  logic                                    s1_valid_r;
  logic                                    s1_excl_r;
  logic                                    s1_alloc_r;
  logic [HNF_MSHR_ENTRIES_WIDTH_PARAM-1:0] s1_entry_r;
  logic                                    s1_upd_s;
  logic [1:0]                              verdict_s;
  logic [1:0]                              q_state_s;

  // RespErr encoding of an entry state: only a passed exclusive reports EXOK.
  function automatic logic [1:0] resperr_of(input logic [1:0] st);
    logic [1:0] r;
    case (st)
      ST_PASS: r = RESP_EXOK;
      default: r = RESP_OK;
    endcase
    return r;
  endfunction

  // A failed exclusive store must not update memory.
  function automatic logic drop_of(input logic [1:0] st);
    logic d;
    case (st)
      ST_FAIL: d = 1'b1;
      default: d = 1'b0;
    endcase
    return d;
  endfunction

  // s0 request capture into the s1 pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_excl_r  <= 1'b0;
      s1_alloc_r <= 1'b0;
      s1_entry_r <= '0;
    end else begin
      s1_valid_r <= li_mshr_rxreq_valid_s0;
      s1_excl_r  <= li_mshr_rxreq_excl_s0;
      s1_alloc_r <= mshr_alloc_en_s0;
      s1_entry_r <= mshr_alloc_entry_s0;
    end
  end

  // s1 verdict decode; a fail wins over a simultaneous pass, and no verdict
  // at all means the opcode was not a supported exclusive.
  always_comb begin
    verdict_s = ST_NONE;
    if (excl_fail_s1) begin
      verdict_s = ST_FAIL;
    end else if (excl_pass_s1) begin
      verdict_s = ST_PASS;
    end else begin
      verdict_s = ST_NONE;
    end
    s1_upd_s = s1_valid_r && s1_excl_r && s1_alloc_r &&
               (state_r[s1_entry_r] == ST_PEND);
  end

  // Next-state for all entries: s1 verdict, then retire, then a fresh
  // allocation, each later write overriding an earlier one on the same entry.
  always_comb begin
    state_nxt_s = state_r;
    if (s1_upd_s) begin
      state_nxt_s[s1_entry_r] = verdict_s;
    end else begin
      state_nxt_s[s1_entry_r] = state_r[s1_entry_r];
    end
    if (mshr_dealloc_en) begin
      state_nxt_s[mshr_dealloc_entry] = ST_NONE;
    end else begin
      state_nxt_s[mshr_dealloc_entry] = state_nxt_s[mshr_dealloc_entry];
    end
    if (mshr_alloc_en_s0) begin
      if (li_mshr_rxreq_valid_s0 && li_mshr_rxreq_excl_s0) begin
        state_nxt_s[mshr_alloc_entry_s0] = ST_PEND;
      end else begin
        state_nxt_s[mshr_alloc_entry_s0] = ST_NONE;
      end
    end else begin
      state_nxt_s[mshr_alloc_entry_s0] = state_nxt_s[mshr_alloc_entry_s0];
    end
    q_state_s = state_nxt_s[rsp_query_entry];
  end

  // Per-entry status storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HNF_MSHR_ENTRIES_NUM_PARAM; i++) begin
        state_r[i] <= ST_NONE;
      end
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Query response; reads the next state so a same-cycle verdict is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_resperr_q     <= RESP_OK;
      rsp_wrdata_drop_q <= 1'b0;
    end else if (rsp_query_valid) begin
      rsp_resperr_q     <= resperr_of(q_state_s);
      rsp_wrdata_drop_q <= drop_of(q_state_s);
    end
  end

`ifdef HNF_MSHR_EXCL_STAT_EN
  logic pass_evt_s;
  logic fail_evt_s;

  // A verdict counts only if it actually lands in the entry.
  always_comb begin
    pass_evt_s = s1_upd_s && (state_nxt_s[s1_entry_r] == ST_PASS);
    fail_evt_s = s1_upd_s && (state_nxt_s[s1_entry_r] == ST_FAIL);
  end

  // Saturating pass/fail event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excl_pass_cnt_q <= 16'h0000;
      excl_fail_cnt_q <= 16'h0000;
    end else begin
      if (pass_evt_s && (excl_pass_cnt_q != 16'hFFFF)) begin
        excl_pass_cnt_q <= excl_pass_cnt_q + 16'd1;
      end
      if (fail_evt_s && (excl_fail_cnt_q != 16'hFFFF)) begin
        excl_fail_cnt_q <= excl_fail_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule
